// File: rtl/matrix_mult_2x2.sv
// Unsigned 2x2 matrix multiplier C = A x B. Operands are loaded one element per clock,
// results are computed on an execute strobe and read back through a combinational mux.
module matrix_mult_2x2 #(
  parameter  int DATA_W = 8,
  localparam int RES_W  = 2 * DATA_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sel_in,
  input  logic [DATA_W-1:0] input_val,
  input  logic              execute,
  input  logic [1:0]        sel_out,
  output logic [RES_W-1:0]  result
);

  // No handshake: the block is always ready. Every rising edge writes input_val into
  // operand sel_in; execute=1 on the same edge loads C from the pre-edge operands.

  // Operand index map: 0..3 = A00,A01,A10,A11 ; 4..7 = B00,B01,B10,B11
  logic [DATA_W-1:0]   opnd_q [8];
  logic [RES_W-1:0]    c_q    [4];
  logic [RES_W-1:0]    c_d    [4];
  logic [2*DATA_W-1:0] prod   [8];

  always_comb begin
    prod[0] = opnd_q[0] * opnd_q[4];
    prod[1] = opnd_q[1] * opnd_q[6];
    prod[2] = opnd_q[0] * opnd_q[5];
    prod[3] = opnd_q[1] * opnd_q[7];
    prod[4] = opnd_q[2] * opnd_q[4];
    prod[5] = opnd_q[3] * opnd_q[6];
    prod[6] = opnd_q[2] * opnd_q[5];
    prod[7] = opnd_q[3] * opnd_q[7];
    for (int i = 0; i < 4; i++) begin
      c_d[i] = {1'b0, prod[2*i]} + {1'b0, prod[2*i+1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) opnd_q[i] <= '0;
      for (int i = 0; i < 4; i++) c_q[i]    <= '0;
    end else begin
      opnd_q[sel_in] <= input_val;
      if (execute) begin
        for (int i = 0; i < 4; i++) c_q[i] <= c_d[i];
      end
    end
  end

  assign result = c_q[sel_out];

endmodule

// File: tb/tb_matrix_mult_2x2.sv
// Directed bench for matrix_mult_2x2: the driver pushes hand-computed expectations
// into a queue and a separate monitor pops and compares on every read request.
module tb_matrix_mult_2x2;

  localparam int DATA_W = 8;
  localparam int RES_W  = 2 * DATA_W + 1;

  logic              clk;
  logic              reset;
  logic [2:0]        sel_in;
  logic [DATA_W-1:0] input_val;
  logic              execute;
  logic [1:0]        sel_out;
  logic [RES_W-1:0]  result;

  logic [RES_W-1:0]  exp_q[$];
  logic [1:0]        sel_q[$];
  event              rd_ev;
  int                n_checks = 0;
  int                n_errors = 0;

  matrix_mult_2x2 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel_in    (sel_in),
    .input_val (input_val),
    .execute   (execute),
    .sel_out   (sel_out),
    .result    (result)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(rd_ev) begin
    logic [RES_W-1:0] exp_v;
    logic [1:0]       s;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_underflow: read request with empty expected queue, result=%0d", result);
    end else begin
      exp_v = exp_q.pop_front();
      s     = sel_q.pop_front();
      if (result !== exp_v) begin
        n_errors++;
        $display("FAIL C%0d%0d at %0t: got %0d, expected %0d", s[1], s[0], $time, result, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rd(input logic [1:0] s, input logic [RES_W-1:0] e);
    sel_out = s;
    #1;
    exp_q.push_back(e);
    sel_q.push_back(s);
    -> rd_ev;
    #1;
  endtask

  task automatic rd_all(input logic [RES_W-1:0] e0, input logic [RES_W-1:0] e1,
                        input logic [RES_W-1:0] e2, input logic [RES_W-1:0] e3);
    rd(2'd0, e0);
    rd(2'd1, e1);
    rd(2'd2, e2);
    rd(2'd3, e3);
  endtask

  task automatic load(input logic [2:0] s, input logic [DATA_W-1:0] v);
    @(negedge clk);
    sel_in    = s;
    input_val = v;
    execute   = 1'b0;
  endtask

  task automatic load_mats(input logic [DATA_W-1:0] m [8]);
    for (int i = 0; i < 8; i++) load(3'(i), m[i]);
  endtask

  task automatic pulse_exec();
    @(negedge clk);
    execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] ex_m  [8];
  logic [DATA_W-1:0] max_m [8];

  initial begin
    // A=[1,2;0,3], B=[3,1;2,1]  ->  C=[7,3;6,3]
    ex_m  = '{8'd1, 8'd2, 8'd0, 8'd3, 8'd3, 8'd1, 8'd2, 8'd1};
    max_m = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};

    reset     = 1'b1;
    sel_in    = 3'd0;
    input_val = '0;
    execute   = 1'b0;
    sel_out   = 2'd0;

    rd_all(17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    reset = 1'b0;

    // Example product
    load_mats(ex_m);
    pulse_exec();
    rd_all(17'd7, 17'd3, 17'd6, 17'd3);

    // Hold while execute low, then one-cycle latency on recompute
    load(3'd0, 8'd0);
    @(negedge clk);
    rd_all(17'd7, 17'd3, 17'd6, 17'd3);
    @(negedge clk);
    execute = 1'b1;
    rd(2'd0, 17'd7);
    @(negedge clk);
    execute = 1'b0;
    // A=[0,2;0,3]: C00=0*3+2*2=4, C01=0*1+2*1=2
    rd_all(17'd4, 17'd2, 17'd6, 17'd3);

    // Restore example data, then write A11=5 on the same edge execute samples high
    load(3'd0, 8'd1);
    pulse_exec();
    rd_all(17'd7, 17'd3, 17'd6, 17'd3);
    @(negedge clk);
    sel_in    = 3'd3;
    input_val = 8'd5;
    execute   = 1'b1;
    @(negedge clk);
    rd_all(17'd7, 17'd3, 17'd6, 17'd3);
    @(negedge clk);
    execute = 1'b0;
    // A=[1,2;0,5]: C10=5*2=10, C11=5*1=5
    rd_all(17'd7, 17'd3, 17'd10, 17'd5);

    // Readout mux sweep on every half-cycle with results stable
    for (int i = 0; i < 8; i++) begin
      logic [RES_W-1:0] sweep_exp [4];
      sweep_exp = '{17'd7, 17'd3, 17'd10, 17'd5};
      @(clk);
      #1;
      rd(2'(i % 4), sweep_exp[i % 4]);
    end

    // Maximum operands: 2*255*255 = 130050 with no truncation
    load_mats(max_m);
    pulse_exec();
    rd_all(17'd130050, 17'd130050, 17'd130050, 17'd130050);

    // Asynchronous reset between edges clears everything immediately
    @(negedge clk);
    #1;
    reset = 1'b1;
    rd_all(17'd0, 17'd0, 17'd0, 17'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    rd_all(17'd0, 17'd0, 17'd0, 17'd0);

    // After reset only the currently driven operand (B11=255) was rewritten: C01=C11=0
    load_mats(ex_m);
    pulse_exec();
    rd_all(17'd7, 17'd3, 17'd6, 17'd3);

    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
